div_seq_ctrl: RTL and testbench
===============================

// Module: div_seq_ctrl
// PURPOSE
//  Sequential controller for the signed non-restoring divide datapath: accepts one DIV op,
//  runs one quotient bit per clock, returns {remainder, quotient} packed for HI/LO.
//  Sits between the control unit (start/done handshake) and the HI/LO register load path.
//  Replaces the single-cycle combinational divide on the critical path.
// PARAMETERS
//  WIDTH  32  operand width; Z is 2*WIDTH; iteration count = WIDTH
// PORTS
//  clock   in   1        rising-edge clock
//  clear   in   1        asynchronous, active-low reset
//  start   in   1        request; sampled only in IDLE
//  A       in   WIDTH    signed dividend, latched when start accepted
//  B       in   WIDTH    signed divisor, latched when start accepted
//  busy    out  1        high from the cycle after acceptance until done
//  done    out  1        one-cycle pulse; Z valid from this cycle on
//  dz      out  1        divide-by-zero flag, valid with done
//  Z       out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}
// BEHAVIOUR
//  Reset (clear=0, any time): state=IDLE, busy=0, done=0, dz=0, Z=0. Internal regs cleared.
//   Op in flight is abandoned; no done issued.
//  FSM: IDLE -> PREP -> ITER(x WIDTH) -> FIX -> SIGN -> IDLE.
//  IDLE: start=1 at edge k latches A, B and sign bits (A[msb], B[msb]) -> PREP.
//  PREP (edge k+1): |A| and |B| as WIDTH-bit unsigned magnitudes. Q=|A|, M=|B| (WIDTH+1 bits),
//   P=0 (WIDTH+1 bits), cnt=0 -> ITER.
//  ITER (edges k+2..k+WIDTH+1): {P,Q} <<= 1. Then P += M if P negative, else P -= M.
//   Q[0] = ~P[msb]. cnt++. Leave ITER after cnt reaches WIDTH-1 -> FIX.
//  FIX: if P negative, P += M -> SIGN.
//  SIGN: Q = -Q if signA^signB. R = -P if signA, else P. Z <= {R[WIDTH-1:0], Q}.
//   done=1 in the following cycle -> IDLE.
//  Latency: done high in the cycle after edge k+WIDTH+3 (35 cycles for WIDTH=32).
//   busy is high for cycles k+1..k+WIDTH+3 and low in the done cycle.
//  Handshake: start ignored while busy. A/B changes after acceptance have no effect.
//   start in the done cycle is accepted (back-to-back; period WIDTH+4 cycles).
//  Z and dz hold their last value until the next SIGN update. done is never high for 2 cycles.
//  Width rules: magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) unsigned.
//   -2^31 / -1 wraps: Q=32'h80000000, R=0. No overflow flag.
// CONFIGURATION
//  DIV_ZERO_DETECT_EN defined: in PREP, if B==0 -> skip ITER/FIX and go to SIGN with
//   Q=all ones, P=|A|. Then normal sign step. Z = {A, Q'} where Q'=32'hFFFFFFFF, or
//   32'h00000001 if A<0. dz=1. done in the cycle after edge k+2.
//  Not defined: B==0 runs the full iteration and yields the same Z values at full latency.
//   dz tied 0.
// TESTING
//  A=100, B=7 -> done at cycle 35, Z=64'h00000002_0000000E, dz=0
//  A=-100, B=7 -> Z=64'hFFFFFFFE_FFFFFFF2; A=100, B=-7 -> Z=64'h00000002_FFFFFFF2
//  A=32'h80000000, B=-1 -> Z=64'h00000000_80000000; A=5, B=9 -> Z=64'h00000005_00000000
//  start re-pulsed with new operands at cycle 10 -> ignored, first result unchanged.
//   start in done cycle -> second done exactly 36 cycles after the first.
//  clear low during ITER (cnt=10) -> busy=0, Z=0 immediately; no done. Next op after
//   clear high is correct.
//  A=-9, B=0 -> Z=64'hFFFFFFF7_00000001. With DIV_ZERO_DETECT_EN: done at cycle 2, dz=1.
//   Without it: done at cycle 35, dz=0.

Source files
------------

// File: rtl/div_seq_ctrl.sv
// Sequential signed non-restoring divider: one quotient bit per clock, result packed as {remainder, quotient}.
// Optional feature: define DIV_ZERO_DETECT_EN to short-circuit divide-by-zero and raise dz.
module div_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic                 dz,
  output logic [2*WIDTH-1:0]   Z
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_SIGN
  } state_t;

  state_t                  state_q;
  logic [WIDTH-1:0]        a_q;
  logic [WIDTH-1:0]        b_q;
  logic                    sa_q;
  logic                    sb_q;
  logic [WIDTH-1:0]        q_q;
  logic signed [WIDTH:0]   p_q;
  logic signed [WIDTH:0]   m_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    busy_q;
  logic                    done_q;
  logic [2*WIDTH-1:0]      z_q;

  logic signed [WIDTH:0]   p_sh_d;
  logic signed [WIDTH:0]   p_step_d;
  logic signed [WIDTH:0]   r_fin_d;
  logic [WIDTH-1:0]        q_fin_d;

  // Unsigned magnitude; the most negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (-v) : v;
  endfunction

  always_comb begin
    p_sh_d   = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
    p_step_d = p_q[WIDTH] ? (p_sh_d + m_q) : (p_sh_d - m_q);
    r_fin_d  = sa_q ? (-p_q) : p_q;
    q_fin_d  = (sa_q ^ sb_q) ? (-q_q) : q_q;
  end

`ifdef DIV_ZERO_DETECT_EN
  logic dz_pend_q;
  logic dz_q;
  assign dz = dz_q;
`else
  assign dz = 1'b0;
`endif

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      q_q       <= '0;
      p_q       <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      z_q       <= '0;
`ifdef DIV_ZERO_DETECT_EN
      dz_pend_q <= 1'b0;
      dz_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            sa_q    <= A[WIDTH-1];
            sb_q    <= B[WIDTH-1];
            busy_q  <= 1'b1;
            state_q <= S_PREP;
          end
        end
        S_PREP: begin
          q_q     <= mag(a_q);
          m_q     <= {1'b0, mag(b_q)};
          p_q     <= '0;
          cnt_q   <= '0;
          state_q <= S_ITER;
`ifdef DIV_ZERO_DETECT_EN
          dz_pend_q <= (b_q == '0);
          // Zero divisor: skip straight to the sign step with the values a full run would produce.
          if (b_q == '0) begin
            q_q     <= '1;
            p_q     <= {1'b0, mag(a_q)};
            state_q <= S_SIGN;
          end
`endif
        end
        S_ITER: begin
          p_q   <= p_step_d;
          q_q   <= {q_q[WIDTH-2:0], ~p_step_d[WIDTH]};
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          if (p_q[WIDTH]) begin
            p_q <= p_q + m_q;
          end
          state_q <= S_SIGN;
        end
        S_SIGN: begin
          z_q     <= {r_fin_d[WIDTH-1:0], q_fin_d};
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
`ifdef DIV_ZERO_DETECT_EN
          dz_q    <= dz_pend_q;
`endif
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Z    = z_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Randomized self-checking bench for div_seq_ctrl against a plain-arithmetic signed-divide model.
// Honours DIV_ZERO_DETECT_EN for expected latency and dz on zero divisors.
module tb_div_seq_ctrl;

  localparam int W = 32;

  logic           clock;
  logic           clear;
  logic           start;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           busy;
  logic           done;
  logic           dz;
  logic [2*W-1:0] Z;

  int n_checks;
  int n_errors;

  div_seq_ctrl #(.WIDTH(W)) dut (
    .clock (clock),
    .clear (clear),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .dz    (dz),
    .Z     (Z)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Truncating signed division; the 64-bit arithmetic makes -2^31 / -1 wrap naturally.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [63:0] ez, output logic edz, output int elat);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == '0) begin
      q = (sa < 0) ? 64'sd1 : -64'sd1;
      r = sa;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    ez = {r[31:0], q[31:0]};
`ifdef DIV_ZERO_DETECT_EN
    edz  = (b == '0);
    elat = (b == '0) ? 2 : W + 3;
`else
    edz  = 1'b0;
    elat = W + 3;
`endif
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit repulse);
    logic [63:0] ez;
    logic        edz;
    int          elat;
    int          lat;
    model(a, b, ez, edz, elat);
    A = a;
    B = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    A = $urandom;
    B = $urandom;
    chk("busy_after_accept", 64'(busy), 64'd1);
    lat = 0;
    while (!done && lat < 100) begin
      if (repulse && lat == 8) begin
        start = 1'b1;
        A = $urandom;
        B = $urandom;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    chk("latency", 64'(lat), 64'(elat));
    chk("Z", Z, ez);
    chk("dz", 64'(dz), 64'(edz));
    chk("busy_in_done", 64'(busy), 64'd0);
    tick();
    chk("done_single", 64'(done), 64'd0);
    chk("Z_hold", Z, ez);
  endtask

  initial begin
    logic [63:0] ez;
    logic        edz;
    int          elat;
    int          lat;
    int          seen;
    logic [W-1:0] ra, rb;

    n_checks = 0;
    n_errors = 0;
    clear = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz", 64'(dz), 64'd0);
    chk("rst_Z", Z, 64'd0);
    clear = 1'b1;
    tick();

    do_op(32'd100, 32'd7, 1'b0);
    do_op(-32'sd100, 32'd7, 1'b0);
    do_op(32'd100, -32'sd7, 1'b0);
    do_op(32'h80000000, 32'hFFFFFFFF, 1'b0);
    do_op(32'd5, 32'd9, 1'b0);
    do_op(-32'sd9, 32'd0, 1'b0);
    do_op(32'd12345, 32'd0, 1'b0);
    do_op(32'h7FFFFFFF, 32'h80000000, 1'b0);
    do_op(32'd1000, 32'd3, 1'b1);

    // Back-to-back: start during the done cycle.
    model(32'd77, 32'd5, ez, edz, elat);
    A = 32'd100; B = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin tick(); lat++; end
    chk("b2b_first_done", 64'(done), 64'd1);
    A = 32'd77; B = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin tick(); lat++; end
    chk("b2b_period", 64'(lat), 64'd36);
    chk("b2b_Z", Z, ez);
    tick();

    // Reset in the middle of the iteration phase abandons the op.
    A = 32'd1000; B = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    chk("busy_before_clear", 64'(busy), 64'd1);
    clear = 1'b0;
    #1;
    chk("clear_busy", 64'(busy), 64'd0);
    chk("clear_Z", Z, 64'd0);
    chk("clear_done", 64'(done), 64'd0);
    #1;
    clear = 1'b1;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (done) seen++;
    end
    chk("no_done_after_clear", 64'(seen), 64'd0);
    do_op(32'd1000, 32'd3, 1'b0);

    for (int i = 0; i < 25; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'hFFFFFFFF;
        2: rb = $urandom_range(1, 16);
        3: rb = -$urandom_range(1, 16);
        4: begin ra = 32'h80000000; rb = $urandom; end
        default: rb = $urandom;
      endcase
      do_op(ra, rb, ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
